// File: rtl/ov5640_capture_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : ov5640_capture_sched_if
//  Purpose  : Request, frame-timing and status bundle for the OV5640 capture
//             scheduler. The slave modport is the scheduler, the master
//             modport is whoever drives requests and frame pulses.
//  Revision : 1.0 - initial release
// ============================================================================
interface ov5640_capture_sched_if;
  logic       gpio_req;
  logic       axil_req;
  logic       frame_sof;
  logic       frame_eof;
  logic       capture_en;
  logic       capture_src;
  logic       busy;
  logic       gpio_done;
  logic       axil_done;
  logic [7:0] frame_cnt;
  logic       timeout_err;

  modport master (
    output gpio_req, axil_req, frame_sof, frame_eof,
    input  capture_en, capture_src, busy, gpio_done, axil_done, frame_cnt, timeout_err
  );

  modport slave (
    input  gpio_req, axil_req, frame_sof, frame_eof,
    output capture_en, capture_src, busy, gpio_done, axil_done, frame_cnt, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/ov5640_capture_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ov5640_capture_sched
//  Purpose  : Arbitrates GPIO / AXI-lite capture requests, aligns each grant
//             to whole camera frames and gates datapath BRAM writes through
//             capture_en. Completion is reported to the granted requester.
//  Options  : CAPTURE_TIMEOUT_EN - adds a 24-bit watchdog that aborts a
//             grant after TIMEOUT_CYCLES cycles in ARMED/CAPTURE.
//  Revision : 1.0 - initial release
// ============================================================================
module ov5640_capture_sched #(
  parameter int FRAMES_PER_REQ = 1,
  parameter int TIMEOUT_CYCLES = 16777215
) (
  input  wire logic               sys_clk_i,
  input  wire logic               sys_rst_i,
  ov5640_capture_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b11,
    S_DONE    = 2'b10
  } state_t;

  localparam logic [3:0]  FRAMES_INIT = 4'(FRAMES_PER_REQ);
  localparam logic [23:0] WD_LIMIT    = 24'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic       gpio_req_q, axil_req_q;
  logic       gpio_pend_q, gpio_pend_d;
  logic       axil_pend_q, axil_pend_d;
  logic       last_axi_q, last_axi_d;
  logic       src_q, src_d;
  logic [3:0] frames_left_q, frames_left_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       gpio_done_q, gpio_done_d;
  logic       axil_done_q, axil_done_d;

  logic       gpio_rise, axil_rise;
  logic       grant, grant_axi;
  logic       timeout_hit;

  assign gpio_rise = bus.gpio_req & ~gpio_req_q;
  assign axil_rise = bus.axil_req & ~axil_req_q;

  // Arbitration, frame alignment, pending queues and completion reporting.
  always_comb begin
    state_d       = state_q;
    last_axi_d    = last_axi_q;
    src_d         = src_q;
    frames_left_d = frames_left_q;
    frame_cnt_d   = frame_cnt_q;
    grant         = 1'b0;
    grant_axi     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gpio_pend_q || axil_pend_q) begin
          grant         = 1'b1;
          // On a tie the source that did not win last time goes first.
          grant_axi     = axil_pend_q && (!gpio_pend_q || !last_axi_q);
          src_d         = grant_axi;
          last_axi_d    = grant_axi;
          frames_left_d = FRAMES_INIT;
          state_d       = S_ARMED;
        end
      end
      S_ARMED: begin
        // A lone eof is ignored so a partially seen frame is never written.
        if (timeout_hit)         state_d = S_DONE;
        else if (bus.frame_sof)  state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A frame that completes on the watchdog cycle still counts.
        if (bus.frame_eof) begin
          frame_cnt_d   = frame_cnt_q + 8'd1;
          frames_left_d = frames_left_q - 4'd1;
          state_d       = (frames_left_q > 4'd1) ? S_ARMED : S_DONE;
        end else if (timeout_hit) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // New edges win over the grant clear so none is lost while busy.
    gpio_pend_d = (gpio_pend_q & ~(grant & ~grant_axi)) | gpio_rise;
    axil_pend_d = (axil_pend_q & ~(grant &  grant_axi)) | axil_rise;

    gpio_done_d = (state_q == S_DONE) && !src_q;

    // axil_done holds until the requester drops its level.
    if ((state_q == S_DONE) && src_q) axil_done_d = 1'b1;
    else if (!bus.axil_req)           axil_done_d = 1'b0;
    else                              axil_done_d = axil_done_q;
  end

  // Scheduler state and status registers.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q       <= S_IDLE;
      gpio_req_q    <= 1'b0;
      axil_req_q    <= 1'b0;
      gpio_pend_q   <= 1'b0;
      axil_pend_q   <= 1'b0;
      last_axi_q    <= 1'b1;
      src_q         <= 1'b0;
      frames_left_q <= 4'd0;
      frame_cnt_q   <= 8'd0;
      gpio_done_q   <= 1'b0;
      axil_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      gpio_req_q    <= bus.gpio_req;
      axil_req_q    <= bus.axil_req;
      gpio_pend_q   <= gpio_pend_d;
      axil_pend_q   <= axil_pend_d;
      last_axi_q    <= last_axi_d;
      src_q         <= src_d;
      frames_left_q <= frames_left_d;
      frame_cnt_q   <= frame_cnt_d;
      gpio_done_q   <= gpio_done_d;
      axil_done_q   <= axil_done_d;
    end
  end

`ifdef CAPTURE_TIMEOUT_EN
  logic [23:0] wd_q;
  logic        timeout_err_q;

  assign timeout_hit = ((state_q == S_ARMED) || (state_q == S_CAPTURE)) && (wd_q == WD_LIMIT);

  // Watchdog counts busy cycles of the current grant; the error flag is sticky until the next grant.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      wd_q          <= 24'd0;
      timeout_err_q <= 1'b0;
    end else begin
      if (grant)
        wd_q <= 24'd0;
      else if ((state_q == S_ARMED) || (state_q == S_CAPTURE))
        wd_q <= wd_q + 24'd1;

      if (grant)
        timeout_err_q <= 1'b0;
      else if (timeout_hit)
        timeout_err_q <= 1'b1;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^WD_LIMIT;
  assign timeout_hit      = 1'b0;
  assign bus.timeout_err  = 1'b0;
`endif

  assign bus.capture_en  = (state_q == S_CAPTURE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.capture_src = src_q;
  assign bus.gpio_done   = gpio_done_q;
  assign bus.axil_done   = axil_done_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire
